// File: rtl/vdf_square_seq.sv
// Repeated-squaring sequencer: x <- x*x mod N for T iterations through one
// external modular multiplier, with abort support and a registered result port.
module vdf_square_seq #(
  parameter int unsigned BITS   = 392,
  parameter int unsigned ITER_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_val,
  input  logic [BITS-1:0]   i_start_x,
  input  logic [ITER_W-1:0] i_iter,
  output logic              o_start_rdy,
  input  logic              i_abort,
  output logic              o_mul_val,
  output logic [BITS-1:0]   o_mul_a,
  output logic [BITS-1:0]   o_mul_b,
  input  logic              i_mul_rdy,
  input  logic              i_mul_val,
  input  logic [BITS-1:0]   i_mul_dat,
  output logic              o_mul_rdy,
  output logic              o_res_val,
  output logic [BITS-1:0]   o_res_dat,
  output logic [ITER_W-1:0] o_res_cnt,
  output logic              o_res_abort,
  input  logic              i_res_rdy,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     x_q, x_d;
  logic [ITER_W-1:0]   rem_q, rem_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                start_rdy_q, start_rdy_d;
  logic                mul_val_q, mul_val_d;
  logic                mul_rdy_q, mul_rdy_d;
  logic                res_val_q, res_val_d;
  logic                busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      start_rdy_q <= 1'b1;
      mul_val_q   <= 1'b0;
      mul_rdy_q   <= 1'b0;
      res_val_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      start_rdy_q <= start_rdy_d;
      mul_val_q   <= mul_val_d;
      mul_rdy_q   <= mul_rdy_d;
      res_val_q   <= res_val_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; handshake outputs are registered copies of the next state
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start_val) begin
          x_d     = i_start_x;
          rem_d   = i_iter;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = (i_iter == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An abort coinciding with the handshake must still drain the product
        if (i_mul_rdy) begin
          state_d = i_abort ? S_DRAIN : S_WAIT;
          if (i_abort) abort_d = 1'b1;
        end else if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT, S_DRAIN: begin
        if (i_abort) abort_d = 1'b1;
        if (i_mul_val) begin
          x_d   = i_mul_dat;
          rem_d = rem_q - ITER_W'(1);
          if (cnt_q != '1) cnt_d = cnt_q + ITER_W'(1);
          if ((rem_q == ITER_W'(1)) || abort_q || i_abort) state_d = S_DONE;
          else                                             state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        if (i_res_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    start_rdy_d = (state_d == S_IDLE);
    mul_val_d   = (state_d == S_ISSUE);
    mul_rdy_d   = (state_d == S_WAIT) || (state_d == S_DRAIN);
    res_val_d   = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign o_start_rdy = start_rdy_q;
  assign o_mul_val   = mul_val_q;
  assign o_mul_a     = x_q;
  assign o_mul_b     = x_q;
  assign o_mul_rdy   = mul_rdy_q;
  assign o_res_val   = res_val_q;
  assign o_res_dat   = x_q;
  assign o_res_cnt   = cnt_q;
  assign o_res_abort = abort_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_vdf_square_seq.sv
// Directed bench for vdf_square_seq with a behavioural mod-N multiplier of
// random latency and a result scoreboard.
module tb_vdf_square_seq;

  localparam int unsigned BITS   = 392;
  localparam int unsigned ITER_W = 32;
  localparam longint unsigned N  = 64'd1000003;

  logic              clk;
  logic              i_rst_n;
  logic              i_start_val;
  logic [BITS-1:0]   i_start_x;
  logic [ITER_W-1:0] i_iter;
  logic              o_start_rdy;
  logic              i_abort;
  logic              o_mul_val;
  logic [BITS-1:0]   o_mul_a;
  logic [BITS-1:0]   o_mul_b;
  logic              i_mul_rdy;
  logic              i_mul_val;
  logic [BITS-1:0]   i_mul_dat;
  logic              o_mul_rdy;
  logic              o_res_val;
  logic [BITS-1:0]   o_res_dat;
  logic [ITER_W-1:0] o_res_cnt;
  logic              o_res_abort;
  logic              i_res_rdy;
  logic              o_busy;

  vdf_square_seq #(.BITS(BITS), .ITER_W(ITER_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start_val (i_start_val),
    .i_start_x   (i_start_x),
    .i_iter      (i_iter),
    .o_start_rdy (o_start_rdy),
    .i_abort     (i_abort),
    .o_mul_val   (o_mul_val),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .i_mul_rdy   (i_mul_rdy),
    .i_mul_val   (i_mul_val),
    .i_mul_dat   (i_mul_dat),
    .o_mul_rdy   (o_mul_rdy),
    .o_res_val   (o_res_val),
    .o_res_dat   (o_res_dat),
    .o_res_cnt   (o_res_cnt),
    .o_res_abort (o_res_abort),
    .i_res_rdy   (i_res_rdy),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned   dat;
    logic [ITER_W-1:0] cnt;
    logic              ab;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int hs       = 0;
  int results  = 0;
  int mul_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int res_mode = 0;   // 0: always ready, 1: random

  bit                pend;
  int                lat;
  logic [BITS-1:0]   prod;
  bit                mstall;
  logic [BITS-1:0]   held_a;
  bit                rstall;
  logic [BITS-1:0]   held_dat;
  logic [ITER_W-1:0] held_cnt;
  logic              held_ab;

  task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned model_sq(input longint unsigned x0, input int unsigned t);
    longint unsigned x;
    x = x0 % N;
    for (int i = 0; i < int'(t); i++) x = (x * x) % N;
    return x;
  endfunction

  // One cycle: advance to the falling edge, then run the multiplier model and
  // result consumer; handshakes decided here complete on the next rising edge.
  task automatic step();
    longint unsigned a;
    longint unsigned p;
    exp_t e;
    @(negedge clk);
    if (!i_rst_n) begin
      pend      = 1'b0;
      mstall    = 1'b0;
      rstall    = 1'b0;
      i_mul_val = 1'b0;
      i_mul_rdy = 1'b0;
      i_res_rdy = 1'b0;
    end else begin
      if (mstall && o_mul_val) chk("mul_a_stable", o_mul_a, held_a);
      i_mul_val = 1'b0;
      if (pend) begin
        if (lat > 0) lat--;
        else begin
          i_mul_val = 1'b1;
          i_mul_dat = prod;
          if (o_mul_rdy) pend = 1'b0;
        end
      end
      case (mul_mode)
        0:       i_mul_rdy = 1'b1;
        1:       i_mul_rdy = 1'($urandom_range(0, 1));
        default: i_mul_rdy = 1'b0;
      endcase
      if (o_mul_val && i_mul_rdy) begin
        chk("mul_a_eq_b", o_mul_a, o_mul_b);
        chk("one_outstanding", BITS'(pend), BITS'(0));
        a    = o_mul_a[63:0];
        p    = (a * a) % N + (($urandom_range(0, 1) == 1) ? N : 64'd0);
        prod = BITS'(p);
        lat  = int'($urandom_range(2, 19));
        pend = 1'b1;
        hs++;
      end
      mstall = o_mul_val && !i_mul_rdy;
      held_a = o_mul_a;

      if (rstall && o_res_val) begin
        chk("res_dat_stable", o_res_dat, held_dat);
        chk("res_cnt_stable", BITS'(o_res_cnt), BITS'(held_cnt));
        chk("res_abort_stable", BITS'(o_res_abort), BITS'(held_ab));
      end
      i_res_rdy = (res_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_res_val && i_res_rdy) begin
        if (q.size() == 0) chk("unexpected_result", BITS'(1), BITS'(0));
        else begin
          e = q.pop_front();
          chk("res_dat_mod_n", o_res_dat % BITS'(N), BITS'(e.dat));
          chk("res_cnt", BITS'(o_res_cnt), BITS'(e.cnt));
          chk("res_abort", BITS'(o_res_abort), BITS'(e.ab));
        end
        results++;
      end
      rstall   = o_res_val && !i_res_rdy;
      held_dat = o_res_dat;
      held_cnt = o_res_cnt;
      held_ab  = o_res_abort;
    end
  endtask

  // Returns at the falling edge of the cycle after the start handshake
  task automatic do_start(input logic [BITS-1:0] x, input logic [ITER_W-1:0] t);
    int n;
    step();
    i_start_val = 1'b1;
    i_start_x   = x;
    i_iter      = t;
    n = 0;
    while (!o_start_rdy && n < 1000) begin
      step();
      n++;
    end
    chk("start_accept_timeout", BITS'(o_start_rdy), BITS'(1));
    step();
    i_start_val = 1'b0;
  endtask

  task automatic wait_result(input int prev);
    int n;
    n = 0;
    while (results == prev && n < 3000) begin
      step();
      n++;
    end
    chk("result_timeout", BITS'(results != prev), BITS'(1));
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs < target && n < 2000) begin
      step();
      n++;
    end
    chk("mul_hs_timeout", BITS'(hs >= target), BITS'(1));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_start_rdy", BITS'(o_start_rdy), BITS'(1));
    chk("rst_mul_val", BITS'(o_mul_val), BITS'(0));
    chk("rst_mul_rdy", BITS'(o_mul_rdy), BITS'(0));
    chk("rst_res_val", BITS'(o_res_val), BITS'(0));
    chk("rst_res_abort", BITS'(o_res_abort), BITS'(0));
    chk("rst_busy", BITS'(o_busy), BITS'(0));
    chk("rst_mul_a", o_mul_a, BITS'(0));
    chk("rst_mul_b", o_mul_b, BITS'(0));
    chk("rst_res_dat", o_res_dat, BITS'(0));
    chk("rst_res_cnt", BITS'(o_res_cnt), BITS'(0));
  endtask

  initial begin
    int h0;
    int r0;
    longint unsigned rx;
    int unsigned rt;

    i_rst_n     = 1'b0;
    i_start_val = 1'b0;
    i_start_x   = '0;
    i_iter      = '0;
    i_abort     = 1'b0;
    i_mul_rdy   = 1'b0;
    i_mul_val   = 1'b0;
    i_mul_dat   = '0;
    i_res_rdy   = 1'b0;
    pend        = 1'b0;
    lat         = 0;
    prod        = '0;
    mstall      = 1'b0;
    held_a      = '0;
    rstall      = 1'b0;
    held_dat    = '0;
    held_cnt    = '0;
    held_ab     = 1'b0;

    step();
    step();
    chk_reset_outputs();
    i_rst_n = 1'b1;

    // x0=3, T=4
    q.push_back('{model_sq(3, 4), ITER_W'(4), 1'b0});
    h0 = hs; r0 = results;
    do_start(BITS'(3), ITER_W'(4));
    chk("issue_cycle1", BITS'(o_mul_val), BITS'(1));
    chk("busy_running", BITS'(o_busy), BITS'(1));
    chk("start_rdy_running", BITS'(o_start_rdy), BITS'(0));
    wait_result(r0);
    chk("t4_mul_hs", BITS'(hs - h0), BITS'(4));

    // T=0 returns the start value in cycle 1 without touching the multiplier
    q.push_back('{64'h1234, ITER_W'(0), 1'b0});
    h0 = hs; r0 = results;
    do_start(BITS'(16'h1234), ITER_W'(0));
    chk("t0_res_cycle1", BITS'(o_res_val), BITS'(1));
    chk("t0_res_dat", o_res_dat, BITS'(16'h1234));
    chk("t0_mul_val", BITS'(o_mul_val), BITS'(0));
    wait_result(r0);
    chk("t0_mul_hs", BITS'(hs - h0), BITS'(0));

    // Random backpressure on both sides, x0=2, T=10
    mul_mode = 1; res_mode = 1;
    q.push_back('{model_sq(2, 10), ITER_W'(10), 1'b0});
    h0 = hs; r0 = results;
    do_start(BITS'(2), ITER_W'(10));
    wait_result(r0);
    chk("bp_mul_hs", BITS'(hs - h0), BITS'(10));
    mul_mode = 0; res_mode = 0;

    // Abort while the first operand is stalled: no product, count 0
    mul_mode = 2;
    q.push_back('{64'd7, ITER_W'(0), 1'b1});
    h0 = hs; r0 = results;
    do_start(BITS'(7), ITER_W'(5));
    chk("stall_issue", BITS'(o_mul_val), BITS'(1));
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    mul_mode = 0;
    wait_result(r0);
    chk("abort_issue_hs", BITS'(hs - h0), BITS'(0));

    // Abort in the 3rd WAIT: 3rd product still consumed, no 4th issue
    q.push_back('{model_sq(5, 3), ITER_W'(3), 1'b1});
    h0 = hs; r0 = results;
    do_start(BITS'(5), ITER_W'(100));
    wait_hs(h0 + 3);
    step();
    chk("abort_in_wait", BITS'(o_mul_rdy), BITS'(1));
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    wait_result(r0);
    chk("abort_wait_hs", BITS'(hs - h0), BITS'(3));

    // Reset during the 2nd WAIT, then a fresh run
    q.push_back('{model_sq(3, 6), ITER_W'(6), 1'b0});
    h0 = hs; r0 = results;
    do_start(BITS'(3), ITER_W'(6));
    wait_hs(h0 + 2);
    step();
    chk("rst_in_wait", BITS'(o_mul_rdy), BITS'(1));
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    step();
    step();
    chk("rst_no_result", BITS'(results), BITS'(r0));
    q.delete();
    i_rst_n = 1'b1;
    q.push_back('{64'd9, ITER_W'(1), 1'b0});
    r0 = results;
    do_start(BITS'(3), ITER_W'(1));
    wait_result(r0);

    // A few random runs with random backpressure
    for (int k = 0; k < 4; k++) begin
      rx = longint'($urandom_range(2, 999999));
      rt = $urandom_range(1, 8);
      mul_mode = k % 2; res_mode = k % 2;
      q.push_back('{model_sq(rx, rt), ITER_W'(rt), 1'b0});
      h0 = hs; r0 = results;
      do_start(BITS'(rx), ITER_W'(rt));
      wait_result(r0);
      chk("rand_mul_hs", BITS'(hs - h0), BITS'(rt));
    end
    mul_mode = 0; res_mode = 0;

    step();
    chk("scoreboard_empty", BITS'(q.size()), BITS'(0));
    chk("idle_busy", BITS'(o_busy), BITS'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
